// File: rtl/attn_mul_lanes.sv
// Attention output multiplier O = S*V: one score row buffered, LANES MAC lanes per V column group.
// Results leave one column group per beat on a backpressured stream.

module attn_mul_lane #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 38,
    parameter int FRAC_BITS  = 14
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         en,
    input  logic                         round_en,
    input  logic                         sat_en,
    input  logic signed [DATA_WIDTH-1:0] s,
    input  logic signed [DATA_WIDTH-1:0] v,
    output logic        [DATA_WIDTH-1:0] res
);
    localparam int PW  = 2 * DATA_WIDTH;
    localparam int EXT = ACC_WIDTH - PW;
    localparam logic signed [ACC_WIDTH:0] RND  = {{ACC_WIDTH{1'b0}}, 1'b1} << (FRAC_BITS - 1);
    localparam logic signed [ACC_WIDTH:0] MAXV = {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] MINV = -MAXV - 1;

    logic signed [PW-1:0]        prod;
    logic signed [ACC_WIDTH-1:0] acc, acc_nxt;
    logic signed [ACC_WIDTH:0]   sum, r;

    // Result is formed from acc_nxt so the product landing in DRAIN is included.
    always_comb begin
        prod    = PW'(s) * PW'(v);
        acc_nxt = en ? acc + $signed({{EXT{prod[PW-1]}}, prod}) : acc;
        sum     = $signed({acc_nxt[ACC_WIDTH-1], acc_nxt}) + (round_en ? RND : '0);
        r       = sum >>> FRAC_BITS;
        if (sat_en && (r > MAXV))
            res = MAXV[DATA_WIDTH-1:0];
        else if (sat_en && (r < MINV))
            res = MINV[DATA_WIDTH-1:0];
        else
            res = r[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc_nxt;
    end
endmodule

module attn_mul_lanes #(
    parameter int DATA_WIDTH = 16,
    parameter int SEQ_LEN    = 64,
    parameter int EMBED_DIM  = 64,
    parameter int LANES      = 4,
    parameter int FRAC_BITS  = 14,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(SEQ_LEN),
    localparam int G  = EMBED_DIM / LANES,
    localparam int AW = $clog2(SEQ_LEN),
    localparam int GW = (G > 1) ? $clog2(G) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        round_en,
    input  logic                        sat_en,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_WIDTH-1:0]       s_data,
    output logic                        v_rd_en,
    output logic [AW-1:0]               v_row,
    output logic [GW-1:0]               v_grp,
    input  logic [LANES*DATA_WIDTH-1:0] v_rdata,
    output logic                        o_valid,
    input  logic                        o_ready,
    output logic [LANES*DATA_WIDTH-1:0] o_data,
    output logic [AW-1:0]               o_row,
    output logic [GW-1:0]               o_grp,
    output logic                        busy,
    output logic                        done
);
    typedef enum logic [2:0] {IDLE, LOAD, MAC, DRAIN, OUT} state_t;
    typedef struct packed {
        logic round_en;
        logic sat_en;
    } cfg_t;

    state_t state, state_nxt;
    cfg_t   cfg;

    logic [AW-1:0] i, j;
    logic [GW-1:0] g;
    logic [SEQ_LEN-1:0][DATA_WIDTH-1:0] score_buf;
    logic signed [DATA_WIDTH-1:0]       s_d;
    logic [LANES-1:0][DATA_WIDTH-1:0]   lane_res;
    logic [1:0] vld_pipe;
    logic last_i, last_j, last_g, s_hs, o_hs, acc_clr, done_nxt;

    assign last_i  = (i == AW'(SEQ_LEN - 1));
    assign last_j  = (j == AW'(SEQ_LEN - 1));
    assign last_g  = (g == GW'(G - 1));
    assign s_ready = (state == LOAD);
    assign v_rd_en = (state == MAC);
    assign o_valid = (state == OUT);
    assign busy    = (state != IDLE);
    assign v_row   = j;
    assign v_grp   = g;
    assign s_hs    = s_ready & s_valid;
    assign o_hs    = o_valid & o_ready;
    assign vld_pipe[0] = v_rd_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = LOAD;
                LOAD:    if (s_hs && last_j) state_nxt = MAC;
                MAC:     if (last_j) state_nxt = DRAIN;
                DRAIN:   state_nxt = OUT;
                OUT: begin
                    if (o_hs) begin
                        if (!last_g)
                            state_nxt = MAC;
                        else if (!last_i)
                            state_nxt = LOAD;
                        else begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Accumulators clear on the edge that enters MAC, from either LOAD or OUT.
    assign acc_clr = (state_nxt == MAC) && (state != MAC);

    always_ff @(posedge clk) begin
        if (s_hs && !abort)
            score_buf[j] <= s_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg         <= '0;
            i           <= '0;
            j           <= '0;
            g           <= '0;
            s_d         <= '0;
            vld_pipe[1] <= 1'b0;
            done        <= 1'b0;
            o_data      <= '0;
            o_row       <= '0;
            o_grp       <= '0;
        end else begin
            vld_pipe[1] <= vld_pipe[0] & ~abort;
            done        <= done_nxt;
            if (abort) begin
                j <= '0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        cfg.round_en <= round_en;
                        cfg.sat_en   <= sat_en;
                        i <= '0;
                        g <= '0;
                        j <= '0;
                    end
                    LOAD: if (s_valid) j <= last_j ? '0 : j + 1'b1;
                    MAC: begin
                        s_d <= score_buf[j];
                        j   <= last_j ? '0 : j + 1'b1;
                    end
                    DRAIN: begin
                        o_data <= lane_res;
                        o_row  <= i;
                        o_grp  <= g;
                    end
                    OUT: if (o_ready) begin
                        if (!last_g)
                            g <= g + 1'b1;
                        else if (!last_i) begin
                            g <= '0;
                            i <= i + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        attn_mul_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .ACC_WIDTH (ACC_WIDTH),
            .FRAC_BITS (FRAC_BITS)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (acc_clr),
            .en      (vld_pipe[1]),
            .round_en(cfg.round_en),
            .sat_en  (cfg.sat_en),
            .s       (s_d),
            .v       (v_rdata[l*DATA_WIDTH +: DATA_WIDTH]),
            .res     (lane_res[l])
        );
    end
endmodule

// File: tb/tb_attn_mul_lanes.sv
// Directed bench for attn_mul_lanes at SEQ_LEN=4, EMBED_DIM=8, LANES=4 with a 1-cycle V RAM model.
module tb_attn_mul_lanes;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, abort, round_en, sat_en, s_valid, s_ready, v_rd_en;
    logic        o_valid, o_ready, busy, done;
    logic [15:0] s_data;
    logic [1:0]  v_row, o_row;
    logic [0:0]  v_grp, o_grp;
    logic [63:0] v_rdata, o_data;

    attn_mul_lanes #(.DATA_WIDTH(16), .SEQ_LEN(4), .EMBED_DIM(8), .LANES(4), .FRAC_BITS(14)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .round_en(round_en),
        .sat_en(sat_en), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .v_rd_en(v_rd_en), .v_row(v_row), .v_grp(v_grp), .v_rdata(v_rdata),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_row(o_row),
        .o_grp(o_grp), .busy(busy), .done(done)
    );

    logic [15:0] Sm [4][4];
    logic [15:0] Vm [4][8];
    logic [15:0] Em [4][8];
    int cyc = 0;
    int out_rd_viol = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (o_valid && v_rd_en) out_rd_viol <= out_rd_viol + 1;
    always @(posedge clk)
        if (v_rd_en)
            for (int l = 0; l < 4; l++) v_rdata[l*16 +: 16] <= Vm[v_row][int'(v_grp)*4 + l];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},    64'(busy),    64'd0);
        chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
        chk({tag, "_o_valid"}, 64'(o_valid), 64'd0);
        chk({tag, "_v_rd_en"}, 64'(v_rd_en), 64'd0);
        chk({tag, "_done"},    64'(done),    64'd0);
        chk({tag, "_o_data"},  o_data,       64'd0);
        chk({tag, "_o_row"},   64'(o_row),   64'd0);
        chk({tag, "_o_grp"},   64'(o_grp),   64'd0);
        chk({tag, "_v_row"},   64'(v_row),   64'd0);
        chk({tag, "_v_grp"},   64'(v_grp),   64'd0);
    endtask

    task automatic send(input logic [15:0] d, input bit gaps);
        int t = 0;
        if (gaps) begin
            s_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) chk("s_ready_timeout", 64'd0, 64'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic recv(input int i, input int g, input bit stall);
        int t = 0;
        bit stable = 1'b1;
        logic [63:0] exp = '0;
        logic [63:0] held;
        while (!o_valid && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) chk("o_valid_timeout", 64'd0, 64'd1);
        for (int l = 0; l < 4; l++) exp[l*16 +: 16] = Em[i][g*4 + l];
        if (stall) begin
            held = o_data;
            repeat (10) begin
                @(negedge clk);
                if (o_data !== held || o_valid !== 1'b1 || o_row !== 2'(i) || o_grp !== 1'(g))
                    stable = 1'b0;
            end
            chk("stall_stable", 64'(stable), 64'd1);
        end
        chk($sformatf("o_data_r%0d_g%0d", i, g), o_data, exp);
        chk($sformatf("o_row_r%0d_g%0d", i, g), 64'(o_row), 64'(i));
        chk($sformatf("o_grp_r%0d_g%0d", i, g), 64'(o_grp), 64'(g));
        o_ready = 1'b1;
        @(negedge clk);
        o_ready = 1'b0;
    endtask

    task automatic run(input bit rnd, input bit sat, input bit stall);
        int t0;
        start = 1'b1; round_en = rnd; sat_en = sat;
        @(negedge clk);
        start = 1'b0; round_en = 1'b0; sat_en = 1'b0;
        t0 = cyc;
        chk("s_ready_after_start", 64'(s_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) send(Sm[i][j], stall);
            for (int g = 0; g < 2; g++) recv(i, g, stall);
        end
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_low_at_done", 64'(busy), 64'd0);
        if (!stall) chk("zero_stall_cycles", 64'(cyc - t0), 64'd64);
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
    endtask

    task automatic fill(input logic [15:0] s, input logic [15:0] v, input logic [15:0] e);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) Sm[r][c] = s;
            for (int c = 0; c < 8; c++) begin Vm[r][c] = v; Em[r][c] = e; end
        end
    endtask

    task automatic fill_identity();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) Sm[r][c] = (r == c) ? 16'h4000 : 16'h0000;
            for (int c = 0; c < 8; c++) begin
                Vm[r][c] = 16'($urandom_range(0, 65535));
                Em[r][c] = Vm[r][c];
            end
        end
    endtask

    initial begin
        int dseen = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; round_en = 1'b0; sat_en = 1'b0;
        s_valid = 1'b0; s_data = '0; o_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Identity S: O must reproduce V, then again under backpressure and score gaps
        fill_identity();
        run(1'b1, 1'b1, 1'b0);
        run(1'b1, 1'b1, 1'b1);

        // 4 x 0.25 x 1.0 = 1.0: every term must be accumulated
        fill(16'h1000, 16'h4000, 16'h4000);
        run(1'b1, 1'b1, 1'b0);

        // 4 x 1.0 x 0x7FFF overflows: clamp vs wrap
        fill(16'h4000, 16'h7FFF, 16'h7FFF);
        run(1'b1, 1'b1, 1'b0);
        fill(16'h4000, 16'h7FFF, 16'hFFFC);
        run(1'b1, 1'b0, 1'b0);

        // Half-LSB result: rounding decides 1 vs 0
        fill(16'h0000, 16'h2000, 16'h0000);
        Sm[0][0] = 16'h0001;
        for (int c = 0; c < 8; c++) Em[0][c] = 16'h0001;
        run(1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 8; c++) Em[0][c] = 16'h0000;
        run(1'b0, 1'b1, 1'b0);

        // Abort in the middle of MAC
        fill(16'h1000, 16'h4000, 16'h4000);
        start = 1'b1; @(negedge clk); start = 1'b0;
        for (int j = 0; j < 4; j++) send(Sm[0][j], 1'b0);
        repeat (2) @(negedge clk);
        chk("in_mac_before_abort", 64'(v_rd_en), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_v_rd_en", 64'(v_rd_en), 64'd0);
        chk("abort_o_valid", 64'(o_valid), 64'd0);
        chk("abort_s_ready", 64'(s_ready), 64'd0);
        repeat (10) begin
            if (done) dseen++;
            @(negedge clk);
        end
        chk("abort_no_done", 64'(dseen), 64'd0);
        run(1'b1, 1'b1, 1'b0);

        // Asynchronous reset in the middle of LOAD
        start = 1'b1; @(negedge clk); start = 1'b0;
        send(Sm[0][0], 1'b0);
        send(Sm[0][1], 1'b0);
        chk("pre_reset_v_row", 64'(v_row), 64'd2);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid_load");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fill_identity();
        run(1'b1, 1'b1, 1'b0);

        chk("no_v_rd_en_in_out", 64'(out_rd_viol), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
